// File: rtl/eight_bit_ram_core_pkg.sv
// Shared widths and word type for the 8x8 scratch RAM.
package eight_bit_ram_core_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/eight_bit_ram_core_if.sv
// Bus bundle for the RAM: write/read select, address, write data and read data.
interface eight_bit_ram_core_if;
  import eight_bit_ram_core_pkg::*;

  logic  wr_rd_en;
  addr_t addr;
  word_t data_in;
  word_t data_out;

  modport master (output wr_rd_en, output addr, output data_in, input data_out);
  modport slave  (input wr_rd_en, input addr, input data_in, output data_out);
endinterface

// File: rtl/eight_bit_ram_core.sv
// Single-port 8x8 RAM: one access per edge, registered read data, async clear.
module eight_bit_ram_core
  import eight_bit_ram_core_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  eight_bit_ram_core_if.slave bus
);

  word_t r_mem [DEPTH];
  word_t r_data_out;
  logic  w_wr;

  // Only an exact 1 selects a write; anything else is treated as a read.
  assign w_wr = (bus.wr_rd_en == 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_data_out <= '0;
    end else if (w_wr) begin
      r_mem[bus.addr] <= bus.data_in;
    end else begin
      r_data_out <= r_mem[bus.addr];
    end
  end

  assign bus.data_out = r_data_out;

endmodule

// File: tb/tb_eight_bit_ram_core.sv
// Scoreboard bench for eight_bit_ram_core: directed cases plus random traffic.
module tb_eight_bit_ram_core;
  logic clk;
  logic rst;

  eight_bit_ram_core_if bus ();

  eight_bit_ram_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] exp;
    logic       wr;
    logic [2:0] addr;
    int         seq;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] model_mem [8];
  logic [7:0] model_out;
  int         checks;
  int         errors;
  int         seq_n;

  // Monitor: each negedge after an access edge, compare data_out with the model.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.data_out !== e.exp) begin
          errors++;
          $display("FAIL data_out seq=%0d %s addr=%0d got=%02h exp=%02h",
                   e.seq, e.wr ? "write" : "read", e.addr, bus.data_out, e.exp);
        end else begin
          $display("ok   seq=%0d %s addr=%0d data_out=%02h",
                   e.seq, e.wr ? "write" : "read", e.addr, bus.data_out);
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model_mem[i] = 8'h00;
    model_out = 8'h00;
  endtask

  // Drive one access now and expect its effect after the next posedge.
  task automatic do_op(input logic wr, input logic [2:0] a, input logic [7:0] d);
    exp_t e;
    bus.wr_rd_en = wr;
    bus.addr     = a;
    bus.data_in  = d;
    @(posedge clk);
    if (wr) model_mem[a] = d;
    else    model_out = model_mem[a];
    e.exp  = model_out;
    e.wr   = wr;
    e.addr = a;
    e.seq  = seq_n;
    seq_n++;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic wr, input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    #1;
    do_op(wr, a, d);
  endtask

  task automatic direct_check(input string name, input logic [7:0] exp);
    checks++;
    if (bus.data_out !== exp) begin
      errors++;
      $display("FAIL %s got=%02h exp=%02h", name, bus.data_out, exp);
    end else begin
      $display("ok   %s data_out=%02h", name, bus.data_out);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    seq_n  = 0;
    rst          = 1'b1;
    bus.wr_rd_en = 1'b0;
    bus.addr     = 3'd0;
    bus.data_in  = 8'h00;
    model_reset();
    #8;
    direct_check("reset_data_out", 8'h00);
    #2;
    rst = 1'b0;

    // 1: every word reads zero after reset
    for (int i = 0; i < 8; i++) cycle(1'b0, 3'(i), 8'h00);

    // 2: write then read
    cycle(1'b1, 3'd0, 8'hAA);
    cycle(1'b0, 3'd0, 8'h00);

    // 3: distinct value per word, no aliasing
    for (int i = 0; i < 8; i++) cycle(1'b1, 3'(i), 8'h10 + 8'(i));
    for (int i = 0; i < 8; i++) cycle(1'b0, 3'(i), 8'h00);

    // 4: data_out holds across a write
    cycle(1'b0, 3'd3, 8'h00);
    cycle(1'b1, 3'd3, 8'hFF);
    cycle(1'b0, 3'd3, 8'h00);

    // 5: async reset between edges, with a write pending during reset
    cycle(1'b1, 3'd7, 8'h5A);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    direct_check("async_reset_immediate", 8'h00);
    model_reset();
    @(posedge clk);
    #1;
    direct_check("reset_held_over_write_edge", 8'h00);
    @(negedge clk);
    #1;
    rst = 1'b0;
    do_op(1'b0, 3'd7, 8'h00);
    cycle(1'b0, 3'd0, 8'h00);

    // 6: back-to-back alternating write/read at the extreme addresses
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 3'd0, 8'h01);
      cycle(1'b0, 3'd0, 8'h00);
      cycle(1'b1, 3'd7, 8'h80);
      cycle(1'b0, 3'd7, 8'h00);
    end

    // Random traffic against the array model
    for (int n = 0; n < 200; n++) begin
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));
    end

    // Drain, bounded
    for (int t = 0; t < 4 && exp_q.size() > 0; t++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
